// File: rtl/mc_ahb_csr_master.sv
// Single-outstanding AHB master for the memory controller CSR slave port.
// Turns valid/ready requests into SINGLE NONSEQ word transfers and reports the completion status.
module mc_ahb_csr_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned MAX_RETRY      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_rsp_timeout,
    output logic [31:0] o_ahb_haddr,
    output logic        o_ahb_hwrite,
    output logic [31:0] o_ahb_hwdata,
    output logic [1:0]  o_ahb_htrans,
    output logic [2:0]  o_ahb_hsize,
    output logic [2:0]  o_ahb_hburst,
    output logic        o_ahb_hsel,
    output logic        o_ahb_hreadyin,
    input  logic        i_ahb_hready,
    input  logic [31:0] i_ahb_hrdata,
    input  logic [1:0]  i_ahb_hresp,
    input  logic        i_ahb_hgrant
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_RETRY   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [RTY_W-1:0]  rty_q, rty_d;
    logic [31:0]       wdata_q, wdata_d;

    logic        req_ready_d, rsp_valid_d, rsp_err_d, rsp_timeout_d;
    logic        hwrite_d, hsel_d;
    logic [31:0] rsp_rdata_d, haddr_d, hwdata_d;
    logic [1:0]  htrans_d;

    assign o_ahb_hsize    = 3'b010;
    assign o_ahb_hburst   = 3'b000;
    assign o_ahb_hreadyin = i_ahb_hready;

    // Next-state and next-output logic; every output register holds unless changed here.
    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        rty_d         = rty_q;
        wdata_d       = wdata_q;
        rsp_rdata_d   = o_rsp_rdata;
        rsp_err_d     = o_rsp_err;
        rsp_timeout_d = o_rsp_timeout;
        haddr_d       = o_ahb_haddr;
        hwrite_d      = o_ahb_hwrite;
        hwdata_d      = o_ahb_hwdata;
        htrans_d      = o_ahb_htrans;
        hsel_d        = o_ahb_hsel;

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid && o_req_ready) begin
                    state_d  = ST_ADDR;
                    rty_d    = '0;
                    wdata_d  = i_req_wdata;
                    haddr_d  = i_req_addr & 32'hFFFF_FFFC;
                    hwrite_d = i_req_write;
                    htrans_d = HTRANS_NONSEQ;
                    hsel_d   = 1'b1;
                end
            end
            ST_ADDR: begin
                if (i_ahb_hready && i_ahb_hgrant) begin
                    state_d  = ST_DATA;
                    htrans_d = HTRANS_IDLE;
                    hsel_d   = 1'b0;
                    hwdata_d = o_ahb_hwrite ? wdata_q : 32'h0;
                    tmo_d    = '0;
                end
            end
            ST_DATA: begin
                if (i_ahb_hready) begin
                    if (i_ahb_hresp == HRESP_OKAY) begin
                        state_d       = ST_RESP;
                        rsp_rdata_d   = o_ahb_hwrite ? 32'h0 : i_ahb_hrdata;
                        rsp_err_d     = 1'b0;
                        rsp_timeout_d = 1'b0;
                    end else if (i_ahb_hresp == HRESP_RETRY && rty_q < RTY_W'(MAX_RETRY)) begin
                        // Reissue the identical address phase; haddr/hwrite were never changed.
                        state_d  = ST_ADDR;
                        rty_d    = rty_q + RTY_W'(1);
                        htrans_d = HTRANS_NONSEQ;
                        hsel_d   = 1'b1;
                    end else begin
                        state_d       = ST_RESP;
                        rsp_rdata_d   = 32'h0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = ST_RESP;
                    tmo_d         = tmo_q + TMO_W'(1);
                    rsp_rdata_d   = 32'h0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    hwdata_d      = 32'h0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tmo_q         <= '0;
            rty_q         <= '0;
            wdata_q       <= 32'h0;
            o_req_ready   <= 1'b0;
            o_rsp_valid   <= 1'b0;
            o_rsp_rdata   <= 32'h0;
            o_rsp_err     <= 1'b0;
            o_rsp_timeout <= 1'b0;
            o_ahb_haddr   <= 32'h0;
            o_ahb_hwrite  <= 1'b0;
            o_ahb_hwdata  <= 32'h0;
            o_ahb_htrans  <= HTRANS_IDLE;
            o_ahb_hsel    <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmo_q         <= tmo_d;
            rty_q         <= rty_d;
            wdata_q       <= wdata_d;
            o_req_ready   <= req_ready_d;
            o_rsp_valid   <= rsp_valid_d;
            o_rsp_rdata   <= rsp_rdata_d;
            o_rsp_err     <= rsp_err_d;
            o_rsp_timeout <= rsp_timeout_d;
            o_ahb_haddr   <= haddr_d;
            o_ahb_hwrite  <= hwrite_d;
            o_ahb_hwdata  <= hwdata_d;
            o_ahb_htrans  <= htrans_d;
            o_ahb_hsel    <= hsel_d;
        end
    end

endmodule
